// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
// State encodings; 2'd3 is unused and treated as idle.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_full_add.sv
// One-bit full adder made from two half-add cells and an OR.
// Sole combinational arithmetic element of the serial adder.
module half_add (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module bit_full_add (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  half_add u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_add u_ha1 (
    .a (s0),
    .b (ci),
    .s (s),
    .c (c1)
  );

  assign co = c0 | c1;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one bit per clock, LSB first,
// with start/ready handshake and a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;
  logic             load;
  logic             step;
  logic             last;
  logic             s_bit;
  logic             c_bit;

  bit_full_add u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (s_bit),
    .co (c_bit)
  );

  assign last = (cnt_q == LAST);

  always_comb begin
    state_nx = ST_IDLE;
    load     = 1'b0;
    step     = 1'b0;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_RUN: begin
        busy     = 1'b1;
        step     = 1'b1;
        state_nx = last ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) begin
          load     = 1'b1;
          state_nx = ST_RUN;
        end
      end
      default: begin
        ready = 1'b1;
        if (start) begin
          load     = 1'b1;
          state_nx = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // sum fills from the MSB end so it is aligned after WIDTH shifts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (load) begin
      a_q     <= a_in;
      b_q     <= b_in;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (step) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      sum_q   <= {s_bit, sum_q[WIDTH-1:1]};
      carry_q <= c_bit;
      cnt_q   <= cnt_q + 1'b1;
      if (last) begin
        cout_q <= c_bit;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
